// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with a one-word fill FSM
// and saturating hit/miss performance counters.
module icache_dm #(
   parameter int NSETS = 16,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             imemREN,
   input  logic [31:0]      imemaddr,
   output logic             ihit,
   output logic [31:0]      imemload,
   output logic             iREN,
   output logic [31:0]      iaddr,
   input  logic             iwait,
   input  logic [31:0]      iload,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int IDX_W = $clog2(NSETS);
   localparam int TAG_W = 30 - IDX_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t state, next_state;

   logic             valid_q [NSETS];
   logic [TAG_W-1:0] tag_q   [NSETS];
   logic [31:0]      data_q  [NSETS];

   // word address of the outstanding miss; byte offset is implicitly zero
   logic [29:0]      miss_word_q;

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] fill_tag;
   logic [IDX_W-1:0] fill_idx;
   logic             lookup_hit;
   logic             fill_we;
   logic             miss_take;
   logic             unused_addr_bits;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   assign req_tag          = imemaddr[31:IDX_W+2];
   assign req_idx          = imemaddr[IDX_W+1:2];
   assign fill_tag         = miss_word_q[29:IDX_W];
   assign fill_idx         = miss_word_q[IDX_W-1:0];
   assign unused_addr_bits = ^imemaddr[1:0];

   assign lookup_hit = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Lookup is suppressed during FETCH, so no hit-under-miss is possible.
   always_comb begin
      next_state = state;
      ihit       = 1'b0;
      iREN       = 1'b0;
      iaddr      = 32'h0;
      fill_we    = 1'b0;
      miss_take  = 1'b0;
      case (state)
         IDLE: begin
            ihit = lookup_hit;
            if (imemREN && !lookup_hit) begin
               miss_take  = 1'b1;
               next_state = FETCH;
            end
         end
         FETCH: begin
            iREN  = 1'b1;
            iaddr = {miss_word_q, 2'b00};
            if (!iwait) begin
               fill_we    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign imemload = ihit ? data_q[req_idx] : 32'h0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NSETS; i++) begin
            valid_q[i] <= 1'b0;
         end
         miss_word_q <= 30'h0;
         hit_cnt     <= '0;
         miss_cnt    <= '0;
      end else begin
         if (fill_we) begin
            valid_q[fill_idx] <= 1'b1;
         end
         if (miss_take) begin
            miss_word_q <= imemaddr[31:2];
            miss_cnt    <= sat_inc(miss_cnt);
         end
         if (ihit) begin
            hit_cnt <= sat_inc(hit_cnt);
         end
      end
   end

   // Tag and data storage carry no reset; the valid bits qualify them.
   always_ff @(posedge CLK) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= iload;
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: fill, re-hit, conflict, redirect,
// reset abort, counter saturation and top-of-memory address.
module tb_icache_dm;

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   logic        ihit4;
   logic [31:0] imemload4;
   logic        iREN4;
   logic [31:0] iaddr4;
   logic [3:0]  hit_cnt4;
   logic [3:0]  miss_cnt4;

   int chks;
   int passes;

   icache_dm #(.NSETS(16), .CNT_W(16)) u_dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   icache_dm #(.NSETS(16), .CNT_W(4)) u_dut4 (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit4), .imemload(imemload4), .iREN(iREN4), .iaddr(iaddr4),
      .iwait(iwait), .iload(iload), .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // advance to 1 time unit after the next rising edge
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic fill(input logic [31:0] a, input logic [31:0] d, input int nw);
      cyc();
      imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
      for (int i = 0; i < nw; i++) cyc();
      cyc();
      iwait = 1'b0; iload = d;
      cyc();
      iwait = 1'b1; iload = 32'h0; imemREN = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; iload = 32'h0;
      #1;
      chks++; if (ihit !== 1'b0) $display("FAIL rst_ihit: got %0b exp 0", ihit); else passes++;
      chks++; if (imemload !== 32'h0) $display("FAIL rst_imemload: got %h exp 0", imemload); else passes++;
      chks++; if (iREN !== 1'b0) $display("FAIL rst_iREN: got %0b exp 0", iREN); else passes++;
      chks++; if (iaddr !== 32'h0) $display("FAIL rst_iaddr: got %h exp 0", iaddr); else passes++;
      cyc(); cyc();
      #4;
      chks++; if (iREN !== 1'b0) $display("FAIL rst_held_iREN: got %0b exp 0", iREN); else passes++;
      chks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0)
         $display("FAIL rst_cnt: got hit %0d miss %0d exp 0 0", hit_cnt, miss_cnt); else passes++;
      chks++; if (hit_cnt4 !== 4'd0 || miss_cnt4 !== 4'd0)
         $display("FAIL rst_cnt4: got hit %0d miss %0d exp 0 0", hit_cnt4, miss_cnt4); else passes++;
      cyc();
      nRST = 1'b1; imemREN = 1'b0;
   endtask

   task automatic test_miss_fill();
      cyc();
      imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
      #4;
      chks++; if (ihit !== 1'b0 || iREN !== 1'b0)
         $display("FAIL miss_lookup: got ihit %0b iREN %0b exp 0 0", ihit, iREN); else passes++;
      for (int i = 0; i < 3; i++) begin
         cyc(); #4;
         chks++; if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0)
            $display("FAIL miss_wait%0d: got iREN %0b iaddr %h ihit %0b exp 1 00000040 0", i, iREN, iaddr, ihit);
         else passes++;
      end
      cyc();
      iwait = 1'b0; iload = 32'h8C010004;
      #4;
      chks++; if (iREN !== 1'b1 || iaddr !== 32'h40)
         $display("FAIL miss_done: got iREN %0b iaddr %h exp 1 00000040", iREN, iaddr); else passes++;
      cyc();
      iwait = 1'b1; iload = 32'h0;
      #4;
      chks++; if (ihit !== 1'b1 || imemload !== 32'h8C010004)
         $display("FAIL miss_hit: got ihit %0b data %h exp 1 8c010004", ihit, imemload); else passes++;
      chks++; if (iREN !== 1'b0 || iaddr !== 32'h0)
         $display("FAIL miss_idle_bus: got iREN %0b iaddr %h exp 0 0", iREN, iaddr); else passes++;
      chks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0)
         $display("FAIL miss_cnt_a: got miss %0d hit %0d exp 1 0", miss_cnt, hit_cnt); else passes++;
      cyc();
      imemREN = 1'b0;
      #4;
      chks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd1)
         $display("FAIL miss_cnt_b: got miss %0d hit %0d exp 1 1", miss_cnt, hit_cnt); else passes++;
      chks++; if (ihit !== 1'b0 || imemload !== 32'h0)
         $display("FAIL noreq: got ihit %0b data %h exp 0 0", ihit, imemload); else passes++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         cyc();
         imemREN = 1'b1; imemaddr = 32'h40;
         #4;
         chks++; if (ihit !== 1'b1 || imemload !== 32'h8C010004 || iREN !== 1'b0)
            $display("FAIL rehit%0d: got ihit %0b data %h iREN %0b exp 1 8c010004 0", i, ihit, imemload, iREN);
         else passes++;
      end
      cyc();
      imemREN = 1'b0;
      #4;
      chks++; if (hit_cnt !== 16'd6 || miss_cnt !== 16'd1)
         $display("FAIL rehit_cnt: got hit %0d miss %0d exp 6 1", hit_cnt, miss_cnt); else passes++;
   endtask

   task automatic test_conflict();
      fill(32'h400, 32'hAAAA0400, 1);
      #4;
      chks++; if (miss_cnt !== 16'd2)
         $display("FAIL conf_cnt_a: got miss %0d exp 2", miss_cnt); else passes++;
      imemREN = 1'b1; imemaddr = 32'h400;
      #1;
      chks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0400)
         $display("FAIL conf_new: got ihit %0b data %h exp 1 aaaa0400", ihit, imemload); else passes++;
      imemaddr = 32'h40;
      #1;
      chks++; if (ihit !== 1'b0)
         $display("FAIL conf_evict: got ihit %0b exp 0", ihit); else passes++;
      cyc();
      #4;
      chks++; if (iREN !== 1'b1 || iaddr !== 32'h40 || miss_cnt !== 16'd3)
         $display("FAIL conf_refetch: got iREN %0b iaddr %h miss %0d exp 1 00000040 3", iREN, iaddr, miss_cnt);
      else passes++;
      iwait = 1'b0; iload = 32'h8C010004;
      cyc();
      iwait = 1'b1; iload = 32'h0;
      #4;
      chks++; if (ihit !== 1'b1 || imemload !== 32'h8C010004)
         $display("FAIL conf_rehit: got ihit %0b data %h exp 1 8c010004", ihit, imemload); else passes++;
      imemREN = 1'b0;
   endtask

   task automatic test_redirect();
      cyc();
      imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1;
      #4;
      chks++; if (ihit !== 1'b0)
         $display("FAIL redir_miss: got ihit %0b exp 0", ihit); else passes++;
      cyc();
      imemaddr = 32'hC0;
      #4;
      chks++; if (iREN !== 1'b1 || iaddr !== 32'h80 || ihit !== 1'b0)
         $display("FAIL redir_fetch: got iREN %0b iaddr %h ihit %0b exp 1 00000080 0", iREN, iaddr, ihit);
      else passes++;
      iwait = 1'b0; iload = 32'h11111111;
      cyc();
      iwait = 1'b1; iload = 32'h0;
      #4;
      chks++; if (ihit !== 1'b0 || iREN !== 1'b0)
         $display("FAIL redir_newmiss: got ihit %0b iREN %0b exp 0 0", ihit, iREN); else passes++;
      imemREN = 1'b0;
      cyc();
      imemREN = 1'b1; imemaddr = 32'h80;
      #4;
      chks++; if (ihit !== 1'b1 || imemload !== 32'h11111111)
         $display("FAIL redir_oldhit: got ihit %0b data %h exp 1 11111111", ihit, imemload); else passes++;
      chks++; if (miss_cnt !== 16'd4)
         $display("FAIL redir_cnt: got miss %0d exp 4", miss_cnt); else passes++;
      cyc();
      imemREN = 1'b0;
   endtask

   task automatic test_reset_midfill();
      cyc();
      imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
      cyc();
      #4;
      chks++; if (iREN !== 1'b1 || iaddr !== 32'h100)
         $display("FAIL rmf_fetch: got iREN %0b iaddr %h exp 1 00000100", iREN, iaddr); else passes++;
      iwait = 1'b0; iload = 32'h33333333;
      #1;
      nRST = 1'b0;
      #1;
      chks++; if (iREN !== 1'b0 || iaddr !== 32'h0)
         $display("FAIL rmf_async: got iREN %0b iaddr %h exp 0 0", iREN, iaddr); else passes++;
      chks++; if (miss_cnt !== 16'd0 || hit_cnt !== 16'd0)
         $display("FAIL rmf_cnt: got miss %0d hit %0d exp 0 0", miss_cnt, hit_cnt); else passes++;
      cyc(); cyc();
      nRST = 1'b1; iwait = 1'b1; iload = 32'h0;
      #4;
      chks++; if (ihit !== 1'b0)
         $display("FAIL rmf_nofill: got ihit %0b exp 0", ihit); else passes++;
      cyc();
      #4;
      chks++; if (iREN !== 1'b1 || miss_cnt !== 16'd1)
         $display("FAIL rmf_refetch: got iREN %0b miss %0d exp 1 1", iREN, miss_cnt); else passes++;
      iwait = 1'b0; iload = 32'h33333333;
      cyc();
      iwait = 1'b1; iload = 32'h0;
      #4;
      chks++; if (ihit !== 1'b1 || imemload !== 32'h33333333)
         $display("FAIL rmf_hit: got ihit %0b data %h exp 1 33333333", ihit, imemload); else passes++;
      imemaddr = 32'h80;
      #1;
      chks++; if (ihit !== 1'b0)
         $display("FAIL rmf_cleared: got ihit %0b exp 0", ihit); else passes++;
      imemREN = 1'b0;
   endtask

   task automatic test_saturation();
      cyc();
      nRST = 1'b0;
      cyc();
      nRST = 1'b1;
      cyc();
      imemREN = 1'b1; imemaddr = 32'hFFFFFFFC; iwait = 1'b1;
      #4;
      chks++; if (ihit !== 1'b0)
         $display("FAIL wrap_miss: got ihit %0b exp 0", ihit); else passes++;
      cyc();
      #4;
      chks++; if (iREN !== 1'b1 || iaddr !== 32'hFFFFFFFC)
         $display("FAIL wrap_iaddr: got iREN %0b iaddr %h exp 1 fffffffc", iREN, iaddr); else passes++;
      iwait = 1'b0; iload = 32'hDEADBEEF;
      cyc();
      iwait = 1'b1; iload = 32'h0;
      for (int i = 0; i < 20; i++) begin
         #4;
         chks++; if (ihit !== 1'b1 || imemload !== 32'hDEADBEEF || ihit4 !== 1'b1)
            $display("FAIL sat_hit%0d: got ihit %0b data %h ihit4 %0b exp 1 deadbeef 1", i, ihit, imemload, ihit4);
         else passes++;
         cyc();
      end
      imemREN = 1'b0;
      #4;
      chks++; if (hit_cnt4 !== 4'd15 || miss_cnt4 !== 4'd1)
         $display("FAIL sat_cnt4: got hit %0d miss %0d exp 15 1", hit_cnt4, miss_cnt4); else passes++;
      chks++; if (hit_cnt !== 16'd20 || miss_cnt !== 16'd1)
         $display("FAIL sat_cnt16: got hit %0d miss %0d exp 20 1", hit_cnt, miss_cnt); else passes++;
      cyc();
      imemREN = 1'b1;
      cyc();
      imemREN = 1'b0;
      #4;
      chks++; if (hit_cnt4 !== 4'd15)
         $display("FAIL sat_hold: got hit %0d exp 15", hit_cnt4); else passes++;
   endtask

   initial begin
      chks = 0; passes = 0;
      nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
      test_reset();
      test_miss_fill();
      test_back_to_back();
      test_conflict();
      test_redirect();
      test_reset_midfill();
      test_saturation();
      $display("%0d/%0d checks passed", passes, chks);
      $finish;
   end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the pipeline's fetch stage (instruction side of the datapath-cache interface) and the memory controller's instruction port.
- Returns `ihit` combinationally on a valid tag match.
- On a miss it runs a one-word fill through a two-state FSM.
- Keeps saturating hit/miss counters for performance checks.

Parameters:
- NSETS, 16, number of frames; power of two, at least 2; IDX_W = log2(NSETS).
- CNT_W, 16, width of the hit and miss counters.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- imemREN  input  1  fetch request from datapath.
- imemaddr  input  32  fetch byte address from datapath; bits [1:0] ignored.
- ihit  output  1  requested word valid this cycle.
- imemload  output  32  instruction word; 0 when ihit=0.
- iREN  output  1  read request to memory controller.
- iaddr  output  32  word-aligned fill address to memory controller.
- iwait  input  1  memory busy; 0 means iload is valid this cycle.
- iload  input  32  fill data from memory controller.
- hit_cnt  output  CNT_W  saturating count of cycles with ihit=1.
- miss_cnt  output  CNT_W  saturating count of IDLE-to-FETCH transitions.

Behaviour:
- Address split:
  - tag = imemaddr[31:IDX_W+2]
  - idx = imemaddr[IDX_W+1:2]
  - Each frame holds a valid bit, a tag and one 32-bit data word.
- Reset (async, nRST=0) and while held:
  - all valid bits = 0; tags/data don't-care.
  - state = IDLE; ihit=0; imemload=0; iREN=0; iaddr=0.
  - hit_cnt=0, miss_cnt=0.
- Reset asserted during FETCH: abort immediately; no frame written; return to IDLE.
- State IDLE:
  - Hit (imemREN=1, valid[idx]=1, tag match): ihit=1 and imemload=data[idx] combinationally in the same cycle; stay IDLE.
  - Miss (imemREN=1, no hit): ihit=0. At the clock edge, latch miss_addr = {imemaddr[31:2], 2'b00}, go to FETCH, miss_cnt++.
  - imemREN=0: ihit=0; no state change; no counting.
- State FETCH:
  - iREN=1 and iaddr=miss_addr, both held stable the whole state.
  - ihit=0 regardless of imemaddr (no hit-under-miss).
  - iwait=1: stay in FETCH.
  - iwait=0: at the edge, write frame[miss_addr idx] with valid=1, tag = miss_addr tag, data = iload; go to IDLE.
- Outside FETCH: iREN=0, iaddr=0.
- Miss latency:
  - lookup cycle, then one FETCH cycle per iwait=1 cycle, then the completing cycle.
  - The hit appears in the first IDLE cycle after the fill.
  - Minimum miss-to-ihit delay is 2 cycles.
- Mid-fill redirect (branch/jump flush changes imemaddr during FETCH):
  - the fill still completes to the latched miss_addr;
  - the new address is looked up in the following IDLE cycle;
  - this may miss again.
- Conflict: a fill evicts whatever frame occupies its index (same idx, different tag); no write-back, since the cache is read-only.
- Address wrap: 0xFFFFFFFC is a legal address (idx = all ones, tag = all ones).
- Counters:
  - hit_cnt increments on each cycle with ihit=1.
  - miss_cnt increments on each IDLE-to-FETCH transition.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- No combinational path from iload to ihit or imemload.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0 with iload=0x8C010004 -> iREN=1 and iaddr=0x40 for 4 cycles; next cycle ihit=1, imemload=0x8C010004; miss_cnt=1, hit_cnt=1.
- After the fill, re-read 0x40 for 5 cycles -> ihit=1 every cycle, iREN=0, hit_cnt increments by 5.
- Conflict: fill 0x40 (idx 0), then fill 0x400 (idx 0, different tag), then read 0x40 -> third access misses; miss_cnt=3; data for 0x40 re-fetched from memory.
- Redirect: miss on 0x80; during FETCH change imemaddr to 0xC0; complete fill with iload=0x11111111 -> frame idx 0 holds tag of 0x80; 0xC0 then misses; a later read of 0x80 hits with 0x11111111.
- Reset mid-fill: assert nRST=0 while FETCH with iwait=1 -> iREN drops asynchronously; after release, a read of the same address misses (no valid frame).
- Saturation with CNT_W=4: 20 consecutive hits -> hit_cnt=15 and remains 15; wrap address 0xFFFFFFFC fills and hits correctly.
